// File: rtl/led_pattern_sequencer_if.sv
// Tick input, mode select and LED/status outputs of the LED pattern sequencer.
interface led_pattern_sequencer_if;
    logic       TICK_IN;
    logic [1:0] MODE;
    logic       YELLOW_LED;
    logic [3:0] STEP;
    logic       TICK_OUT;
    logic       WRAP;

    modport master (
        output TICK_IN, MODE,
        input  YELLOW_LED, STEP, TICK_OUT, WRAP
    );

    modport slave (
        input  TICK_IN, MODE,
        output YELLOW_LED, STEP, TICK_OUT, WRAP
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// 16-step LED pattern engine clocked by synchronised slow-divider ticks.
// LED_SEQ_BREATHE_EN: mode 2 becomes PWM breathing instead of steady on.
module led_pattern_sequencer #(
    parameter int unsigned TICKS_PER_STEP = 16
) (
    input logic                    CLK,
    input logic                    RST,
    led_pattern_sequencer_if.slave bus
);
    localparam int unsigned TCNT_W = 8;
    localparam int unsigned STEP_W = 4;
    localparam int unsigned MODE_W = 2;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICKS_PER_STEP - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = '1;

    logic              s1, s2, s3;
    logic              sync_live;
    logic              armed;
    logic [TCNT_W-1:0] tcnt;
    logic [STEP_W-1:0] step;
    logic [MODE_W-1:0] amode;
    logic              led;
    logic              tick_out;
    logic              wrap;

    logic              tick_evt_c;
    logic              step_end_c;
    logic              wrap_c;
    logic [15:0]       pattern_c;
    logic              led_c;

    // An input already high at reset release must fall (seen by s1) before it may count.
    always_comb begin
        tick_evt_c = s2 & ~s3 & armed;
        step_end_c = (tcnt == TCNT_LAST);
        wrap_c     = tick_evt_c & step_end_c & (step == STEP_LAST);
    end

    always_comb begin
        pattern_c = 16'h0000;
        case (amode)
            2'd0:    pattern_c = 16'h00FF;
            2'd1:    pattern_c = 16'h0005;
            2'd2:    pattern_c = 16'hFFFF;
            default: pattern_c = 16'h0000;
        endcase
    end

`ifdef LED_SEQ_BREATHE_EN
    logic [7:0] phase;
    logic [7:0] pwm;
    logic [7:0] level_c;

    // Triangle-wave brightness from the tick phase, compared against a free-running PWM ramp.
    always_comb begin
        level_c = phase[7] ? {~phase[6:0], 1'b0} : {phase[6:0], 1'b0};
        led_c   = (amode == 2'd2) ? (pwm < level_c) : pattern_c[step];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase <= '0;
            pwm   <= '0;
        end else begin
            pwm <= pwm + 8'd1;
            if (tick_evt_c) begin
                phase <= phase + 8'd1;
            end
        end
    end
`else
    always_comb begin
        led_c = pattern_c[step];
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            sync_live <= 1'b0;
            armed     <= 1'b0;
            tcnt      <= '0;
            step      <= '0;
            amode     <= bus.MODE;
            led       <= 1'b0;
            tick_out  <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            s1        <= bus.TICK_IN;
            s2        <= s1;
            s3        <= s2;
            sync_live <= 1'b1;
            armed     <= armed | (sync_live & ~s1);
            tick_out  <= tick_evt_c;
            wrap      <= wrap_c;
            led       <= led_c;
            if (tick_evt_c) begin
                if (step_end_c) begin
                    tcnt <= '0;
                    step <= step + STEP_W'(1);
                end else begin
                    tcnt <= tcnt + TCNT_W'(1);
                end
            end
            // Mode changes take effect only from step 0 of the next period.
            if (wrap_c) begin
                amode <= bus.MODE;
            end
        end
    end

    assign bus.YELLOW_LED = led;
    assign bus.STEP       = step;
    assign bus.TICK_OUT   = tick_out;
    assign bus.WRAP       = wrap;
endmodule
